// File: rtl/ifu_fill_ctrl.sv
// rtl/ifu_fill_ctrl.sv - IFU instruction-cache miss-fill controller
//
// Ports:
//   Clock, Rst                  clock, asynchronous active-high reset
//   cpu_miss*                   demand miss request (valid/tag/ready)
//   pf_req*                     prefetch request (valid/tag/ready)
//   mem_req*                    line request to memory (valid/tag/ready)
//   mem_rsp*                    memory response (valid/tag/line)
//   fill_*                      one-cycle registered insert pulse to the cache
//   busyOut, timeoutOut         request in flight / re-issue pulse
module ifu_fill_ctrl #(
  parameter int TAG_WIDTH      = 28,
  parameter int LINE_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic                  cpu_missValidIn,
  input  logic [TAG_WIDTH-1:0]  cpu_missTagIn,
  output logic                  cpu_missReadyOut,
  input  logic                  pf_reqValidIn,
  input  logic [TAG_WIDTH-1:0]  pf_reqTagIn,
  output logic                  pf_reqReadyOut,
  output logic                  mem_reqValidOut,
  output logic [TAG_WIDTH-1:0]  mem_reqTagOut,
  input  logic                  mem_reqReadyIn,
  input  logic                  mem_rspValidIn,
  input  logic [TAG_WIDTH-1:0]  mem_rspTagIn,
  input  logic [LINE_WIDTH-1:0] mem_rspLineIn,
  output logic                  fill_validOut,
  output logic [TAG_WIDTH-1:0]  fill_tagOut,
  output logic [LINE_WIDTH-1:0] fill_lineOut,
  output logic                  fill_isPrefetchOut,
  output logic                  busyOut,
  output logic                  timeoutOut
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t               state, state_nxt;
  logic [TAG_WIDTH-1:0] cur_tag, tag_nxt;
  logic                 cur_is_pf, pf_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 fill_fire, timeout_fire;
  logic                 promote, rsp_hit;

  // The request tag is the in-flight tag; it only changes on accept, so it
  // naturally holds its value while mem_reqValidOut is low.
  assign mem_reqTagOut = cur_tag;

  // A demand miss for the line already being prefetched upgrades that fill
  // instead of being accepted as a second request.
  assign promote = (state != S_IDLE) && cur_is_pf && cpu_missValidIn &&
                   (cpu_missTagIn == cur_tag);
  assign rsp_hit = mem_rspValidIn && (mem_rspTagIn == cur_tag);

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state     <= S_IDLE;
      cur_tag   <= '0;
      cur_is_pf <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      cur_tag   <= tag_nxt;
      cur_is_pf <= pf_nxt;
      cnt       <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    tag_nxt          = cur_tag;
    pf_nxt           = cur_is_pf;
    cnt_nxt          = cnt;
    fill_fire        = 1'b0;
    timeout_fire     = 1'b0;
    cpu_missReadyOut = 1'b0;
    pf_reqReadyOut   = 1'b0;
    if (promote) begin
      pf_nxt = 1'b0;
    end
    case (state)
      S_IDLE: begin
        cpu_missReadyOut = 1'b1;
        pf_reqReadyOut   = !cpu_missValidIn;
        if (cpu_missValidIn) begin
          tag_nxt   = cpu_missTagIn;
          pf_nxt    = 1'b0;
          state_nxt = S_REQ;
        end else if (pf_reqValidIn) begin
          tag_nxt   = pf_reqTagIn;
          pf_nxt    = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_reqReadyIn) begin
          cnt_nxt   = '0;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A hit on the expiry cycle takes precedence over the re-issue.
        if (rsp_hit) begin
          fill_fire = 1'b1;
          state_nxt = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout_fire = 1'b1;
          state_nxt    = S_REQ;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      mem_reqValidOut    <= 1'b0;
      busyOut            <= 1'b0;
      timeoutOut         <= 1'b0;
      fill_validOut      <= 1'b0;
      fill_tagOut        <= '0;
      fill_lineOut       <= '0;
      fill_isPrefetchOut <= 1'b0;
    end else begin
      mem_reqValidOut <= (state_nxt == S_REQ);
      busyOut         <= (state_nxt != S_IDLE);
      timeoutOut      <= timeout_fire;
      fill_validOut   <= fill_fire;
      if (fill_fire) begin
        fill_tagOut        <= cur_tag;
        fill_lineOut       <= mem_rspLineIn;
        // pf_nxt already folds in a same-cycle promotion.
        fill_isPrefetchOut <= pf_nxt;
      end
    end
  end

endmodule
